// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer
//   Read-side consumer for a FIFO built on single-port RAM. It watches the
//   FIFO empty flag and issues read enables. It captures RAM read data
//   RD_LAT cycles later into a small skid buffer. Words leave in FIFO order
//   on a valid/ready stream.
//
//   Output handshake: a word transfers on a rising edge where m_valid and
//   m_ready are both high. While m_valid is high and m_ready is low,
//   m_valid stays high and m_data stays stable. m_valid never depends on
//   m_ready. fifo_re does depend combinationally on m_ready, so a pop frees
//   a slot in the same cycle.
//
//   Parameters
//     DATA_WIDTH   word width
//     RD_LAT       RAM read latency, 1 or 2 cycles
//   Optional feature (macro FIFO_RD_CNT_EN)
//     Adds word_cnt[15:0]. It counts pops, saturates at 16'hFFFF, and is
//     cleared by reset and on the IDLE -> RUN transition.
//
//   Ports
//     clk, rst_n     clock, asynchronous active-low reset
//     en             1 = fetch from FIFO, 0 = stop issuing reads
//     fifo_empty     FIFO empty flag
//     fifo_re        read enable to FIFO controller / RAM
//     fifo_rd_data   RAM read data, valid RD_LAT cycles after fifo_re
//     m_valid/m_ready/m_data   output stream
//     busy           FSM not idle, or reads in flight, or words buffered
//     word_cnt       pop counter (FIFO_RD_CNT_EN only)
module fifo_read_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  fifo_empty,
   output logic                  fifo_re,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  busy
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [15:0]           word_cnt
`endif
);

   // One slot per read that can be in flight, plus one for the head word.
   // This is enough to keep one word per clock under backpressure.
   localparam int SKID = RD_LAT + 1;
   localparam int PW   = $clog2(SKID);
   localparam int CW   = $clog2(SKID + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [RD_LAT-1:0]     vpipe;
   logic [3:0]            inflight;
   logic [CW-1:0]         occ;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [DATA_WIDTH-1:0] skid_mem [SKID];
   logic                  pop;
   logic                  arrive;

   assign pop     = m_valid & m_ready;
   assign arrive  = vpipe[RD_LAT-1];
   assign m_valid = (occ != '0);
   assign m_data  = skid_mem[rd_ptr];
   assign busy    = (state != IDLE) | (inflight != 4'd0) | m_valid;

   // Read only when the buffer has a free slot after this cycle's pop. Every
   // outstanding read already reserves a slot. The compare is written as
   // occ + inflight < SKID + pop so that nothing can underflow.
   assign fifo_re = (state == RUN) & ~fifo_empty &
                    ((4'(occ) + inflight) < (4'(SKID) + 4'(pop)));

   always_comb begin
      inflight = 4'd0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + 4'(vpipe[i]);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (en) state_next = RUN;
         RUN:     if (!en) state_next = STOP;
         STOP:    if (inflight == 4'd0) state_next = en ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Each stage of the valid pipe marks a read whose data is still in the RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vpipe <= '0;
      end else begin
         vpipe[0] <= fifo_re;
         for (int i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
      end
   end

   // Skid buffer. SKID is 3 when RD_LAT is 2, so the pointers wrap by
   // compare-and-clear rather than by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < SKID; i++) skid_mem[i] <= '0;
      end else begin
         if (arrive) begin
            skid_mem[wr_ptr] <= fifo_rd_data;
            wr_ptr <= (wr_ptr == PW'(SKID - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == PW'(SKID - 1)) ? '0 : rd_ptr + 1'b1;
         case ({arrive, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

`ifdef FIFO_RD_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           word_cnt <= 16'd0;
      else if (state == IDLE && en)         word_cnt <= 16'd0;
      else if (pop && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
   end
`else
   // Without the counter, the block has no extra state.
`endif

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Testbench for fifo_read_streamer. It runs two instances: lane 0 with
// RD_LAT=1 and lane 1 with RD_LAT=2. Each lane has a FIFO/RAM model with
// the matching read latency. The reference model is a word sequence: every
// word the FIFO hands out must appear on the output stream exactly once and
// in order. Define FIFO_RD_CNT_EN to also check word_cnt.
module tb_fifo_read_streamer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en           [2];
   logic       fifo_empty   [2];
   logic       fifo_re      [2];
   logic [7:0] fifo_rd_data [2];
   logic       m_valid      [2];
   logic       m_ready      [2];
   logic [7:0] m_data       [2];
   logic       busy         [2];
`ifdef FIFO_RD_CNT_EN
   logic [15:0] word_cnt    [2];
`endif

   int checks = 0;
   int errors = 0;

   // clock / reset
   always #5 clk = ~clk;

   fifo_read_streamer #(.DATA_WIDTH(8), .RD_LAT(1)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en[0]), .fifo_empty(fifo_empty[0]),
      .fifo_re(fifo_re[0]), .fifo_rd_data(fifo_rd_data[0]),
      .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
      .busy(busy[0])
`ifdef FIFO_RD_CNT_EN
      , .word_cnt(word_cnt[0])
`endif
   );

   fifo_read_streamer #(.DATA_WIDTH(8), .RD_LAT(2)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en[1]), .fifo_empty(fifo_empty[1]),
      .fifo_re(fifo_re[1]), .fifo_rd_data(fifo_rd_data[1]),
      .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
      .busy(busy[1])
`ifdef FIFO_RD_CNT_EN
      , .word_cnt(word_cnt[1])
`endif
   );

   // FIFO + RAM model. Contents live in mem. A read accepted at an edge
   // returns its word RD_LAT cycles after fifo_re. Cycles with no valid data
   // carry random junk, so a wrong capture cycle shows up as bad data.
   logic [7:0] mem [2][4096];
   int         fill_cnt [2] = '{0, 0};
   int         rd_idx   [2] = '{0, 0};
   logic [7:0] dp0;
   logic [7:0] dp1 [2];
   logic [7:0] exp_q [2][$];

   assign fifo_empty[0]   = (rd_idx[0] == fill_cnt[0]);
   assign fifo_empty[1]   = (rd_idx[1] == fill_cnt[1]);
   assign fifo_rd_data[0] = dp0;
   assign fifo_rd_data[1] = dp1[1];

   always @(posedge clk) begin
      dp0    <= fifo_re[0] ? mem[0][rd_idx[0]] : 8'($urandom);
      dp1[0] <= fifo_re[1] ? mem[1][rd_idx[1]] : 8'($urandom);
      dp1[1] <= dp1[0];
      for (int l = 0; l < 2; l++) begin
         if (fifo_re[l]) begin
            exp_q[l].push_back(mem[l][rd_idx[l]]);
            rd_idx[l] <= rd_idx[l] + 1;
         end
      end
   end

   // Scoreboard / protocol monitor. It samples at the falling edge, and the
   // tasks drive inputs just after the rising edge.
   int         pops      [2] = '{0, 0};
   int         occ_max   [2] = '{0, 0};
   logic       hold_pend [2] = '{1'b0, 1'b0};
   logic [7:0] hold_data [2];
   logic [7:0] e;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int l = 0; l < 2; l++) begin
            if (hold_pend[l]) begin
               checks++;
               if (m_valid[l] !== 1'b1 || m_data[l] !== hold_data[l]) begin
                  errors++;
                  $display("FAIL hold lane%0d: got valid=%b data=%h, required valid=1 data=%h",
                           l, m_valid[l], m_data[l], hold_data[l]);
               end
            end
            hold_pend[l] = m_valid[l] && !m_ready[l];
            hold_data[l] = m_data[l];
            if (m_valid[l] && m_ready[l]) begin
               checks++;
               if (exp_q[l].size() == 0) begin
                  errors++;
                  $display("FAIL extra_word lane%0d: got %h, required no word", l, m_data[l]);
               end else begin
                  e = exp_q[l].pop_front();
                  if (m_data[l] !== e) begin
                     errors++;
                     $display("FAIL order lane%0d: got %h, required %h", l, m_data[l], e);
                  end
               end
               pops[l]++;
            end
            checks++;
            if (fifo_re[l] === 1'b1 && fifo_empty[l]) begin
               errors++;
               $display("FAIL re_on_empty lane%0d: got fifo_re=1, required 0", l);
            end
         end
         if (int'(u0.occ) > occ_max[0]) occ_max[0] = int'(u0.occ);
         if (int'(u1.occ) > occ_max[1]) occ_max[1] = int'(u1.occ);
         checks++;
         if (int'(u0.occ) > 2 || int'(u1.occ) > 3) begin
            errors++;
            $display("FAIL occ_bound: got %0d/%0d, required <=2/<=3", u0.occ, u1.occ);
         end
      end else begin
         hold_pend = '{1'b0, 1'b0};
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_seq(input int l, input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         mem[l][fill_cnt[l]] = base + 8'(i);
         fill_cnt[l]++;
      end
   endtask

   task automatic load_rand(input int l, input int n);
      for (int i = 0; i < n; i++) begin
         mem[l][fill_cnt[l]] = 8'($urandom_range(0, 255));
         fill_cnt[l]++;
      end
   endtask

   // Drop en and wait for the lane to drain. Any words left in the FIFO are
   // discarded so the next scenario starts from an empty FIFO.
   task automatic stop_and_drain(input int l);
      int k;
      en[l] = 1'b0;
      for (k = 0; k < 100; k++) begin
         if (!busy[l] && !m_valid[l]) break;
         tick(1);
      end
      checks++;
      if (k == 100) begin
         errors++;
         $display("FAIL drain_timeout lane%0d: got busy=%b, required 0", l, busy[l]);
      end
      checks++;
      if (exp_q[l].size() != 0) begin
         errors++;
         $display("FAIL lost_words lane%0d: got %0d undelivered, required 0", l, exp_q[l].size());
      end
      fill_cnt[l] = rd_idx[l];
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int l = 0; l < 2; l++) begin
         en[l] = 1'b0;
         m_ready[l] = 1'b0;
      end
      for (int c = 0; c < 3; c++) begin
         tick(1);
         for (int l = 0; l < 2; l++) begin
            checks++;
            if (fifo_re[l] !== 1'b0 || m_valid[l] !== 1'b0 || m_data[l] !== 8'h00 || busy[l] !== 1'b0) begin
               errors++;
               $display("FAIL reset lane%0d: got re=%b v=%b d=%h busy=%b, required 0 0 00 0",
                        l, fifo_re[l], m_valid[l], m_data[l], busy[l]);
            end
`ifdef FIFO_RD_CNT_EN
            checks++;
            if (word_cnt[l] !== 16'd0) begin
               errors++;
               $display("FAIL reset_cnt lane%0d: got %0d, required 0", l, word_cnt[l]);
            end
`endif
         end
      end
      rst_n = 1'b1;
      tick(2);
      checks++;
      if (busy[0] !== 1'b0 || busy[1] !== 1'b0 || fifo_re[0] !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got busy=%b/%b re=%b, required 0/0 0", busy[0], busy[1], fifo_re[0]);
      end
   endtask

   // Lane latency is RD_LAT+1 cycles after en is sampled, then one word per clock.
   task automatic test_stream(input int l, input int lat);
      int k;
      int p0;
      p0 = pops[l];
      load_seq(l, 8'h11, 8);
      m_ready[l] = 1'b1;
      en[l] = 1'b1;
      for (k = 1; k <= 10; k++) begin
         tick(1);
         if (m_valid[l]) break;
      end
      checks++;
      if (k != lat + 2) begin
         errors++;
         $display("FAIL latency lane%0d: got %0d edges, required %0d", l, k, lat + 2);
      end
      for (int i = 1; i < 8; i++) begin
         tick(1);
         checks++;
         if (m_valid[l] !== 1'b1) begin
            errors++;
            $display("FAIL throughput lane%0d cycle %0d: got valid=%b, required 1", l, i, m_valid[l]);
         end
      end
      tick(1);
      checks++;
      if (m_valid[l] !== 1'b0 || fifo_re[l] !== 1'b0 || pops[l] - p0 != 8) begin
         errors++;
         $display("FAIL stream_end lane%0d: got valid=%b re=%b pops=%0d, required 0 0 8",
                  l, m_valid[l], fifo_re[l], pops[l] - p0);
      end
      stop_and_drain(l);
   endtask

   task automatic test_backpressure();
      int k;
      int p0;
      p0 = pops[0];
      occ_max[0] = 0;
      load_seq(0, 8'h11, 8);
      m_ready[0] = 1'b0;
      en[0] = 1'b1;
      tick(6);
      checks++;
      if (fifo_re[0] !== 1'b0 || m_valid[0] !== 1'b1 || m_data[0] !== 8'h11 || occ_max[0] != 2) begin
         errors++;
         $display("FAIL stall: got re=%b v=%b d=%h occmax=%0d, required 0 1 11 2",
                  fifo_re[0], m_valid[0], m_data[0], occ_max[0]);
      end
      m_ready[0] = 1'b1;
      for (k = 0; k < 40; k++) begin
         if (pops[0] - p0 == 8) break;
         tick(1);
      end
      checks++;
      if (pops[0] - p0 != 8) begin
         errors++;
         $display("FAIL bp_count: got %0d words, required 8", pops[0] - p0);
      end
      stop_and_drain(0);
   endtask

   task automatic test_en_drop();
      int k;
      int p0;
      int r0;
      p0 = pops[0];
      r0 = rd_idx[0];
      load_rand(0, 8);
      m_ready[0] = 1'b1;
      en[0] = 1'b1;
      // Reads 1 and 2 have been taken. The read already enabled in this cycle
      // is the third one. After it, the lane enters STOP and issues nothing.
      for (k = 0; k < 20; k++) begin
         if (rd_idx[0] - r0 == 2) break;
         tick(1);
      end
      en[0] = 1'b0;
      tick(1);
      checks++;
      if (busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL stop_busy: got busy=%b, required 1", busy[0]);
      end
      stop_and_drain(0);
      checks++;
      if (pops[0] - p0 != 3 || rd_idx[0] - r0 != 3) begin
         errors++;
         $display("FAIL en_drop: got delivered=%0d read=%0d, required 3 3", pops[0] - p0, rd_idx[0] - r0);
      end
   endtask

   task automatic test_rdlat2_toggle();
      int k;
      int p0;
      p0 = pops[1];
      occ_max[1] = 0;
      load_rand(1, 6);
      m_ready[1] = 1'b1;
      en[1] = 1'b1;
      for (k = 0; k < 60; k++) begin
         if (pops[1] - p0 == 6) break;
         tick(1);
         m_ready[1] = ~m_ready[1];
      end
      m_ready[1] = 1'b1;
      checks++;
      if (pops[1] - p0 != 6 || occ_max[1] > 3) begin
         errors++;
         $display("FAIL rdlat2: got words=%0d occmax=%0d, required 6 <=3", pops[1] - p0, occ_max[1]);
      end
      stop_and_drain(1);
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         for (int l = 0; l < 2; l++) begin
            if ($urandom_range(0, 1) == 1) load_rand(l, 1);
            m_ready[l] = ($urandom_range(0, 3) != 0);
            en[l] = ($urandom_range(0, 15) != 0);
         end
         tick(1);
      end
      for (int l = 0; l < 2; l++) begin
         m_ready[l] = 1'b1;
         stop_and_drain(l);
      end
   endtask

`ifdef FIFO_RD_CNT_EN
   task automatic test_word_cnt();
      load_rand(0, 5);
      m_ready[0] = 1'b1;
      en[0] = 1'b1;
      tick(1);
      en[0] = 1'b0;
      en[0] = 1'b1;
      tick(12);
      stop_and_drain(0);
      tick(2);
      checks++;
      if (word_cnt[0] !== 16'd5) begin
         errors++;
         $display("FAIL word_cnt: got %0d, required 5", word_cnt[0]);
      end
      en[0] = 1'b1;
      tick(1);
      checks++;
      if (word_cnt[0] !== 16'd0) begin
         errors++;
         $display("FAIL word_cnt_clear: got %0d, required 0", word_cnt[0]);
      end
      stop_and_drain(0);
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream(0, 1);
      test_stream(1, 2);
      test_backpressure();
      test_en_drop();
      test_rdlat2_toggle();
      test_random();
`ifdef FIFO_RD_CNT_EN
      test_word_cnt();
`endif
      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
